// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: responder state encoding, select-width
// derivation and the status-bit positions used by the host-side master.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_ERR  = 2'd3
  } wb_state_e;

  // Bit positions inside the master's status word (busy/ack/err/timeout)
  typedef enum int {
    STAT_BUSY_BIT    = 0,
    STAT_ACK_BIT     = 1,
    STAT_ERR_BIT     = 2,
    STAT_TIMEOUT_BIT = 3
  } wb_stat_bit_e;

  function automatic int wb_sel_width(input int bus_width);
    return bus_width / 8;
  endfunction

endpackage

// File: rtl/wb_slave_mem_if.sv
// Wishbone classic bus bundle between the bridge master and the memory responder.
interface wb_slave_mem_if #(
  parameter int BUS_W  = 16,
  parameter int ADDR_W = 32
) ();
  import wb_pkg::*;

  localparam int SEL_W = wb_sel_width(BUS_W);

  logic              cyc;
  logic              stb;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [BUS_W-1:0]  wdata;
  logic [SEL_W-1:0]  sel;
  logic [BUS_W-1:0]  rdata;
  logic              ack;
  logic              err;
  logic              rty;
  logic              stall;

  modport master (
    output cyc, stb, we, lock, addr, wdata, sel,
    input  rdata, ack, err, rty, stall
  );

  modport slave (
    input  cyc, stb, we, lock, addr, wdata, sel,
    output rdata, ack, err, rty, stall
  );

endinterface

// File: rtl/wb_sel_ram.sv
// Single-port RAM with per-byte write enables; the read port is a register
// that only updates on a read access, so it doubles as the bus read-data hold.
module wb_sel_ram #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [SEL_W-1:0]  be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Byte-lane write; storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (be[i]) begin
          mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Read register: loads only on a read access, holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if (en && !we) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic-cycle memory responder with byte-lane writes, configurable
// wait states, error response outside the decoded window and transfer counters.
module wb_slave_mem
  import wb_pkg::*;
#(
  parameter int                         WB_BUS_WIDTH  = 16,
  parameter int                         WB_ADDR_WIDTH = 32,
  parameter int                         MEM_DEPTH     = 256,
  parameter logic [WB_ADDR_WIDTH-1:0]   BASE_ADDR     = '0,
  parameter int                         WAIT_STATES   = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_reset_n_i,
  wb_slave_mem_if.slave         bus,
  output logic [15:0]           xfer_cnt_o,
  output logic [15:0]           err_cnt_o
);

  localparam int OFF_W = $clog2(MEM_DEPTH);
  localparam int SEL_W = wb_sel_width(WB_BUS_WIDTH);
  localparam logic [WB_ADDR_WIDTH:0] DEPTH_EXT = (WB_ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

  wb_state_e              state_r;
  wb_state_e              next_state_s;
  logic [3:0]             cnt_r;
  logic                   we_r;
  logic [OFF_W-1:0]       off_r;
  logic [WB_BUS_WIDTH-1:0] wdata_r;
  logic [SEL_W-1:0]       sel_r;

  logic                   ack_r;
  logic                   err_r;
  logic                   stall_r;
  logic [15:0]            xfer_cnt_r;
  logic [15:0]            err_cnt_r;

  logic                   req_s;
  logic [WB_ADDR_WIDTH-1:0] diff_s;
  logic                   in_range_s;
  logic                   ack_s;
  logic                   err_s;
  logic                   stall_s;
  logic                   ram_en_s;
  logic                   ram_we_s;
  logic [OFF_W-1:0]       ram_addr_s;
  logic [SEL_W-1:0]       ram_be_s;
  logic [WB_BUS_WIDTH-1:0] ram_wdata_s;
  logic                   unused_lock_s;

  assign req_s = bus.cyc & bus.stb;

  // Check the lower bound first so the subtraction can never wrap into the window
  assign diff_s     = bus.addr - BASE_ADDR;
  assign in_range_s = (bus.addr >= BASE_ADDR) && ({1'b0, diff_s} < DEPTH_EXT);

  assign unused_lock_s = bus.lock;

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!req_s) begin
          next_state_s = ST_IDLE;
        end else if (!in_range_s) begin
          next_state_s = ST_ERR;
        end else if (WAIT_STATES == 0) begin
          next_state_s = ST_ACK;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.cyc) begin
          next_state_s = ST_IDLE;
        end else if (cnt_r == 4'd0) begin
          next_state_s = ST_ACK;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_ACK:  next_state_s = ST_IDLE;
      ST_ERR:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output decode; with zero wait states the RAM is fed straight from the bus
  always_comb begin
    ack_s    = (next_state_s == ST_ACK);
    err_s    = (next_state_s == ST_ERR);
    stall_s  = (next_state_s != ST_IDLE);
    ram_en_s = ack_s;
    if (state_r == ST_IDLE) begin
      ram_we_s    = bus.we;
      ram_addr_s  = diff_s[OFF_W-1:0];
      ram_be_s    = bus.sel;
      ram_wdata_s = bus.wdata;
    end else begin
      ram_we_s    = we_r;
      ram_addr_s  = off_r;
      ram_be_s    = sel_r;
      ram_wdata_s = wdata_r;
    end
  end

  // Request capture and wait-state countdown
  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      off_r   <= '0;
      wdata_r <= '0;
      sel_r   <= '0;
    end else if (state_r == ST_IDLE) begin
      cnt_r <= WS_LOAD;
      if (req_s) begin
        we_r    <= bus.we;
        off_r   <= diff_s[OFF_W-1:0];
        wdata_r <= bus.wdata;
        sel_r   <= bus.sel;
      end
    end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Registered handshake outputs and wrapping counters
  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      stall_r    <= 1'b0;
      xfer_cnt_r <= 16'd0;
      err_cnt_r  <= 16'd0;
    end else begin
      ack_r   <= ack_s;
      err_r   <= err_s;
      stall_r <= stall_s;
      if (ack_s) begin
        xfer_cnt_r <= xfer_cnt_r + 16'd1;
      end
      if (err_s) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end
  end

  wb_sel_ram #(
    .DATA_W (WB_BUS_WIDTH),
    .DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk   (wb_clk_i),
    .rst_n (wb_reset_n_i),
    .en    (ram_en_s),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .be    (ram_be_s),
    .wdata (ram_wdata_s),
    .rdata (bus.rdata)
  );

  assign bus.ack    = ack_r;
  assign bus.err    = err_r;
  assign bus.rty    = 1'b0;
  assign bus.stall  = stall_r;
  assign xfer_cnt_o = xfer_cnt_r;
  assign err_cnt_o  = err_cnt_r;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem: one instance with 1 wait state, one with 3.
module tb_wb_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] xfer1, errc1, xfer3, errc3;
  int          n_checks = 0;
  int          n_pass = 0;

  wb_slave_mem_if #(.BUS_W(16), .ADDR_W(32)) m1 ();
  wb_slave_mem_if #(.BUS_W(16), .ADDR_W(32)) m3 ();

  wb_slave_mem #(.WAIT_STATES(1)) dut1 (
    .wb_clk_i(clk), .wb_reset_n_i(rst_n), .bus(m1), .xfer_cnt_o(xfer1), .err_cnt_o(errc1)
  );
  wb_slave_mem #(.WAIT_STATES(3)) dut3 (
    .wb_clk_i(clk), .wb_reset_n_i(rst_n), .bus(m3), .xfer_cnt_o(xfer3), .err_cnt_o(errc3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  task automatic drive(input bit b3, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] addr, input logic [15:0] d, input logic [1:0] sel);
    if (b3) begin
      m3.cyc = cyc; m3.stb = stb; m3.we = we; m3.addr = addr; m3.wdata = d; m3.sel = sel; m3.lock = 1'b0;
    end else begin
      m1.cyc = cyc; m1.stb = stb; m1.we = we; m1.addr = addr; m1.wdata = d; m1.sel = sel; m1.lock = 1'b0;
    end
  endtask

  task automatic sample(input bit b3, output logic a, output logic e, output logic s,
                        output logic [15:0] rd);
    if (b3) begin a = m3.ack; e = m3.err; s = m3.stall; rd = m3.rdata; end
    else    begin a = m1.ack; e = m1.err; s = m1.stall; rd = m1.rdata; end
  endtask

  // One complete transfer; returns cycles from request to termination
  task automatic xfer(input bit b3, input logic we, input logic [31:0] addr, input logic [15:0] d,
                      input logic [1:0] sel, output int lat, output logic got_ack,
                      output logic got_err, output logic [15:0] rd);
    logic a, e, s;
    drive(b3, 1'b1, 1'b1, we, addr, d, sel);
    lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = 16'h0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      sample(b3, a, e, s, rd);
      check("stall_busy", {31'd0, s}, 32'd1);
      if (a || e) begin
        got_ack = a; got_err = e;
        break;
      end
    end
    check("terminated", {31'd0, got_ack | got_err}, 32'd1);
    drive(b3, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00);
    @(posedge clk); #1;
    sample(b3, a, e, s, rd);
    check("pulse_end_ack", {31'd0, a}, 32'd0);
    check("pulse_end_err", {31'd0, e}, 32'd0);
    check("idle_stall", {31'd0, s}, 32'd0);
  endtask

  initial begin
    int          lat;
    logic        a, e, s;
    logic [15:0] rd;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, m1.ack}, 32'd0);
    check("rst_err", {31'd0, m1.err}, 32'd0);
    check("rst_stall", {31'd0, m1.stall}, 32'd0);
    check("rst_rty", {31'd0, m1.rty}, 32'd0);
    check("rst_data", {16'd0, m1.rdata}, 32'd0);
    check("rst_xfer", {16'd0, xfer1}, 32'd0);
    check("rst_errc", {16'd0, errc1}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-word write then read
    xfer(1'b0, 1'b1, 32'h10, 16'hBEEF, 2'b11, lat, a, e, rd);
    check("wr_lat", lat, 32'd2);
    check("wr_ack", {31'd0, a}, 32'd1);
    xfer(1'b0, 1'b0, 32'h10, 16'h0000, 2'b11, lat, a, e, rd);
    check("rd_lat", lat, 32'd2);
    check("rd_data", {16'd0, rd}, 32'h0000BEEF);
    check("xfer_2", {16'd0, xfer1}, 32'd2);

    // Partial-lane and empty-select writes
    xfer(1'b0, 1'b1, 32'h10, 16'h1234, 2'b01, lat, a, e, rd);
    xfer(1'b0, 1'b0, 32'h10, 16'h0000, 2'b11, lat, a, e, rd);
    check("sel01_data", {16'd0, rd}, 32'h0000BE34);
    xfer(1'b0, 1'b1, 32'h10, 16'hFFFF, 2'b00, lat, a, e, rd);
    check("sel00_ack", {31'd0, a}, 32'd1);
    xfer(1'b0, 1'b0, 32'h10, 16'h0000, 2'b10, lat, a, e, rd);
    check("sel00_data", {16'd0, rd}, 32'h0000BE34);
    check("xfer_6", {16'd0, xfer1}, 32'd6);

    // Out-of-window accesses, including the top of the address space
    xfer(1'b0, 1'b0, 32'h100, 16'h0000, 2'b11, lat, a, e, rd);
    check("err_lat", lat, 32'd1);
    check("err_flag", {31'd0, e}, 32'd1);
    check("err_noack", {31'd0, a}, 32'd0);
    check("err_cnt_1", {16'd0, errc1}, 32'd1);
    check("err_data_hold", {16'd0, m1.rdata}, 32'h0000BE34);
    xfer(1'b0, 1'b1, 32'hFFFF_FFFF, 16'h7777, 2'b11, lat, a, e, rd);
    check("err_top", {31'd0, e}, 32'd1);
    check("err_cnt_2", {16'd0, errc1}, 32'd2);
    check("xfer_after_err", {16'd0, xfer1}, 32'd6);

    // Last word in the window
    xfer(1'b0, 1'b1, 32'hFF, 16'h5A5A, 2'b11, lat, a, e, rd);
    check("last_wr_ack", {31'd0, a}, 32'd1);
    xfer(1'b0, 1'b0, 32'hFF, 16'h0000, 2'b11, lat, a, e, rd);
    check("last_rd_data", {16'd0, rd}, 32'h00005A5A);
    xfer(1'b0, 1'b1, 32'h11, 16'hC0DE, 2'b11, lat, a, e, rd);
    check("xfer_9", {16'd0, xfer1}, 32'd9);

    // Three wait states: completed write, then an aborted overwrite
    xfer(1'b1, 1'b1, 32'h20, 16'h1111, 2'b11, lat, a, e, rd);
    check("ws3_lat", lat, 32'd4);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 16'hAAAA, 2'b11);
    repeat (2) begin @(posedge clk); #1; end
    check("abort_stall", {31'd0, m3.stall}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_noack", {31'd0, m3.ack}, 32'd0);
    end
    check("abort_idle", {31'd0, m3.stall}, 32'd0);
    xfer(1'b1, 1'b0, 32'h20, 16'h0000, 2'b11, lat, a, e, rd);
    check("abort_old_data", {16'd0, rd}, 32'h00001111);
    check("abort_xfer", {16'd0, xfer3}, 32'd2);

    // Asynchronous reset in the middle of a wait
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 16'h0, 2'b11);
    @(posedge clk); #1;
    check("pre_rst_stall", {31'd0, m1.stall}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_stall", {31'd0, m1.stall}, 32'd0);
    check("arst_ack", {31'd0, m1.ack}, 32'd0);
    check("arst_data", {16'd0, m1.rdata}, 32'd0);
    check("arst_xfer", {16'd0, xfer1}, 32'd0);
    check("arst_errc", {16'd0, errc1}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00);
    #2 rst_n = 1'b1;
    xfer(1'b0, 1'b0, 32'h10, 16'h0000, 2'b11, lat, a, e, rd);
    check("post_rst_data", {16'd0, rd}, 32'h0000BE34);
    check("post_rst_xfer", {16'd0, xfer1}, 32'd1);

    // Back-to-back reads with strobe held through the ack
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 16'h0, 2'b11);
    repeat (2) begin @(posedge clk); #1; end
    check("b2b_ack1", {31'd0, m1.ack}, 32'd1);
    check("b2b_data1", {16'd0, m1.rdata}, 32'h0000BE34);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h11, 16'h0, 2'b11);
    @(posedge clk); #1;
    check("b2b_gap_ack", {31'd0, m1.ack}, 32'd0);
    check("b2b_gap_stall", {31'd0, m1.stall}, 32'd0);
    @(posedge clk); #1;
    check("b2b_wait_stall", {31'd0, m1.stall}, 32'd1);
    check("b2b_wait_ack", {31'd0, m1.ack}, 32'd0);
    @(posedge clk); #1;
    check("b2b_ack2", {31'd0, m1.ack}, 32'd1);
    check("b2b_data2", {16'd0, m1.rdata}, 32'h0000C0DE);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00);
    @(posedge clk); #1;
    check("b2b_end_ack", {31'd0, m1.ack}, 32'd0);
    check("b2b_xfer", {16'd0, xfer1}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_slave_mem.md
Name: wb_slave_mem

Overview:
Wishbone classic-cycle responder: a word-addressed memory with byte-lane writes and a configurable number of wait states. Out-of-window accesses receive an error response. It is the target end of the Wishbone link that the host-side bridge master drives, and it lets that master be exercised with reads, writes, selects, wait states and errors. Also provides completed-transfer and error counters for the status/LED path.

Parameters:
WB_BUS_WIDTH, 16, data width in bits; must be a multiple of 8.
WB_ADDR_WIDTH, 32, address width (word address).
MEM_DEPTH, 256, number of words; power of two.
BASE_ADDR, 0, first word address decoded by the block.
WAIT_STATES, 1, cycles inserted between request capture and ack; 0..15.

Ports:
wb_clk_i  in  1  clock
wb_reset_n_i  in  1  asynchronous active-low reset
wb_cyc_i  in  1  cycle valid
wb_stb_i  in  1  strobe
wb_we_i  in  1  1 = write
wb_addr_i  in  WB_ADDR_WIDTH  word address
wb_data_i  in  WB_BUS_WIDTH  write data
wb_sel_i  in  WB_BUS_WIDTH/8  byte-lane enables
wb_lock_i  in  1  ignored
wb_data_o  out  WB_BUS_WIDTH  read data, registered
wb_ack_o  out  1  normal termination, one-cycle pulse
wb_err_o  out  1  error termination, one-cycle pulse
wb_rty_o  out  1  constant 0
wb_stall_o  out  1  high whenever state != IDLE
xfer_cnt_o  out  16  count of acked transfers, wraps
err_cnt_o  out  16  count of err terminations, wraps

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE; wb_data_o, wb_ack_o, wb_err_o, wb_stall_o, wait counter, xfer_cnt_o and err_cnt_o all 0. Memory contents are not reset.
- Request = wb_cyc_i & wb_stb_i sampled in IDLE. Capture we, addr offset (addr-BASE_ADDR), data and sel.
- Decode: in range iff addr >= BASE_ADDR and addr-BASE_ADDR < MEM_DEPTH. Width-safe compare; no wrap-around aliasing.
- State machine:
  - IDLE: request and out of range -> ERR. Request and WAIT_STATES==0 -> ACK. Request otherwise -> WAIT, counter=WAIT_STATES-1.
  - WAIT: if wb_cyc_i drops -> IDLE (abort, no write, no counter update). Else if counter==0 -> ACK, else decrement.
  - ACK: wb_ack_o=1 for this single cycle. Next state is always IDLE.
  - ERR: wb_err_o=1 for this single cycle. Next state is always IDLE.
- Latency from request edge to ack visible: WAIT_STATES+1 cycles. Error is visible 1 cycle after the request.
- Write is committed on the edge entering ACK, to lanes with sel[i]=1 only. sel=0 still acks with no memory change.
- Read: wb_data_o loaded on the edge entering ACK with mem[offset], full word regardless of sel. It holds its value until the next read ack; writes and errors leave it unchanged.
- ack and err are never high together. The ack/err pulse never exceeds 1 cycle, even if stb stays high; stb seen in the IDLE following ACK starts a new transfer.
- xfer_cnt_o increments on the edge entering ACK; err_cnt_o on the edge entering ERR; both wrap 0xFFFF->0.
- Reset mid-transfer: immediate return to IDLE with outputs 0. A pending write is dropped.

Decomposition:
- Shared package wb_pkg: state encoding (IDLE, WAIT, ACK, ERR) and WB_SEL derivation (WB_BUS_WIDTH/8). The existing master's status-bit constants move here as well.
- One natural sub-module: wb_sel_ram, a single-port RAM with per-byte write enable and registered read. Data, address, byte-enable and write strobe are driven by the FSM.

Test Plan:
- Write 0xBEEF to addr 0x10 with sel=2'b11, then read 0x10 -> ack 2 cycles after each request (WAIT_STATES=1), wb_data_o=0xBEEF, xfer_cnt_o=2.
- Write 0x1234 sel=2'b01 over 0xBEEF at 0x10, then read -> 0xBE34. Then write with sel=2'b00 and read -> still 0xBE34, ack still given.
- Read addr 0x100 (MEM_DEPTH=256, BASE_ADDR=0) -> wb_err_o pulse 1 cycle after request, no ack, err_cnt_o=1, wb_data_o unchanged.
- WAIT_STATES=3: drop wb_cyc_i during WAIT on a write of 0xAAAA to 0x20 -> no ack, return to IDLE. A subsequent read of 0x20 shows the old data; xfer_cnt_o counts the read only.
- Assert wb_reset_n_i low during WAIT -> all outputs 0 immediately (asynchronously), state IDLE. After release, a normal read completes.
- Back-to-back: keep stb high across ACK for two reads of 0x10 and 0x11 -> two separate single-cycle acks. wb_stall_o is high in every non-IDLE cycle.
